// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and types for the programmable clock divider.
//   DIV_W_DEF        default width of half-period divisors and channel counters
//   DIV_100_TO_25    half-period that turns the 100 MHz board clock into 25 MHz
//   DEFAULT_HALF_DEF divisor every channel starts with after reset
//   div_t            divisor/counter type at the default width
// -----------------------------------------------------------------------------
package clk_div_pkg;

  localparam int DIV_W_DEF        = 16;
  localparam int DIV_100_TO_25    = 2;
  localparam int DEFAULT_HALF_DEF = DIV_100_TO_25;

  typedef logic [DIV_W_DEF-1:0] div_t;

endpackage : clk_div_pkg

// File: rtl/clk_div_prog_if.sv
// -----------------------------------------------------------------------------
// clk_div_prog_if
// Control/status bundle of the divider block.
//   en        global run enable (low freezes every channel's counter)
//   load      one-cycle strobe writing div_value into ch_sel's pending divisor
//   ch_sel    target channel of load (values >= NUM_CH are ignored)
//   div_value new half-period in clock cycles, 0 disables the channel
//   clk_out   divided clocks, one bit per channel
//   tick      one-cycle strobe when the matching clk_out toggles
//   busy      a channel holds a pending divisor not yet applied
// master drives control and reads status; slave is the divider itself.
// -----------------------------------------------------------------------------
interface clk_div_prog_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = DIV_W_DEF
);

  logic              en;
  logic              load;
  logic [2:0]        ch_sel;
  logic [DIV_W-1:0]  div_value;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] busy;

  modport master (
    output en, load, ch_sel, div_value,
    input  clk_out, tick, busy
  );

  modport slave (
    input  en, load, ch_sel, div_value,
    output clk_out, tick, busy
  );

endinterface : clk_div_prog_if

// File: rtl/clk_div_chan.sv
// -----------------------------------------------------------------------------
// clk_div_chan
// One divider channel: counter, active and pending divisors, output toggle,
// tick strobe and busy flag.
//   clk_i        system clock
//   rst_i        synchronous active-high reset
//   en_i         run enable; low holds counter and clk_out, suppresses tick
//   load_i       capture div_value_i as the pending divisor
//   div_value_i  half-period to capture
//   clk_out_o    divided clock, 50% duty, period 2*D
//   tick_o       high in the cycle a new clk_out value is visible
//   busy_o       pending divisor waiting for the next wrap
// A pending divisor only takes effect on a wrap edge so the output never
// produces a runt phase; a disabled channel (D = 0) applies it immediately.
// -----------------------------------------------------------------------------
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_value_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             busy_o
);

  logic [DIV_W-1:0] cnt_q,  cnt_d;
  logic [DIV_W-1:0] act_q,  act_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             clk_q,  clk_d;
  logic             tick_q, tick_d;

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path through
    // the branches below can leave one unassigned and infer a latch.
    cnt_d  = cnt_q;
    act_d  = act_q;
    pend_d = pend_q;
    busy_d = busy_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (en_i) begin
      if (act_q == '0) begin
        // Disabled: adopt any pending value right away, restart the count.
        if (busy_q) begin
          act_d  = pend_q;
          busy_d = 1'b0;
          cnt_d  = '0;
        end
      end else if (cnt_q == act_q - DIV_W'(1)) begin
        cnt_d = '0;
        if (busy_q) begin
          act_d  = pend_q;
          busy_d = 1'b0;
        end
        if (busy_q && pend_q == '0) begin
          clk_d = 1'b0;
        end else begin
          clk_d  = ~clk_q;
          tick_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end

    // A load on the apply edge lands after the apply: the old pending value
    // is consumed and the new one waits for the following wrap.
    if (load_i) begin
      pend_d = div_value_i;
      busy_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      act_q  <= DIV_W'(DEFAULT_HALF);
      pend_q <= DIV_W'(DEFAULT_HALF);
      busy_q <= 1'b0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      pend_q <= pend_d;
      busy_q <= busy_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign busy_o    = busy_q;

endmodule : clk_div_chan

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Multi-channel programmable clock divider / enable generator.
//   clk100_mhz  100 MHz system clock
//   reset       synchronous active-high reset
//   bus         clk_div_prog_if slave: en, load, ch_sel, div_value in;
//               clk_out, tick, busy out (one bit per channel)
// The top only decodes the shared load port into per-channel strobes.
// -----------------------------------------------------------------------------
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = DIV_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic           clk100_mhz,
  input  logic           reset,
  clk_div_prog_if.slave  bus
);

  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] busy_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    // ch_sel values with no matching channel simply hit no strobe.
    logic load_w;
    assign load_w = bus.load && (bus.ch_sel == 3'(i));

    clk_div_chan #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_chan (
      .clk_i        (clk100_mhz),
      .rst_i        (reset),
      .en_i         (bus.en),
      .load_i       (load_w),
      .div_value_i  (bus.div_value),
      .clk_out_o    (clk_out_w[i]),
      .tick_o       (tick_w[i]),
      .busy_o       (busy_w[i])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.busy    = busy_w;

endmodule : clk_div_prog

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// tb_clk_div_prog
// Self-checking bench for clk_div_prog. A per-channel behavioural model
// (edges left until next toggle, output level, pending value) predicts
// clk_out/tick/busy every cycle; directed scenarios add fixed expectations.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int NUM_CH = 2;
  localparam int DIV_W  = 16;
  localparam int DEF    = 2;

  logic clk100_mhz = 1'b0;
  logic reset;

  clk_div_prog_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

  clk_div_prog #(
    .NUM_CH       (NUM_CH),
    .DIV_W        (DIV_W),
    .DEFAULT_HALF (DEF)
  ) dut (
    .clk100_mhz (clk100_mhz),
    .reset      (reset),
    .bus        (bus.slave)
  );

  always #5 clk100_mhz = ~clk100_mhz;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: one entry per channel.
  int m_d    [NUM_CH];   // active half-period
  int m_pend [NUM_CH];   // last loaded value
  bit m_pv   [NUM_CH];   // a loaded value is waiting
  int m_left [NUM_CH];   // enabled edges remaining until the next toggle
  bit m_lvl  [NUM_CH];
  bit m_tick [NUM_CH];

  task automatic model_edge();
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) begin
        m_d[c] = DEF; m_pend[c] = DEF; m_pv[c] = 0;
        m_left[c] = DEF; m_lvl[c] = 0; m_tick[c] = 0;
      end else begin
        m_tick[c] = 0;
        if (bus.en) begin
          if (m_d[c] == 0) begin
            if (m_pv[c]) begin
              m_d[c] = m_pend[c]; m_pv[c] = 0; m_left[c] = m_d[c];
            end
          end else begin
            m_left[c]--;
            if (m_left[c] == 0) begin
              if (m_pv[c]) begin m_d[c] = m_pend[c]; m_pv[c] = 0; end
              if (m_d[c] == 0) m_lvl[c] = 0;
              else begin m_lvl[c] = ~m_lvl[c]; m_tick[c] = 1; end
              m_left[c] = m_d[c];
            end
          end
        end
        if (bus.load && int'(bus.ch_sel) == c) begin
          m_pend[c] = int'(bus.div_value); m_pv[c] = 1;
        end
      end
    end
  endtask

  // One clock edge: model follows the inputs, outputs compared mid-cycle.
  task automatic step();
    @(posedge clk100_mhz);
    model_edge();
    @(negedge clk100_mhz);
    for (int c = 0; c < NUM_CH; c++) begin
      check($sformatf("ch%0d clk_out", c), 32'(bus.clk_out[c]), 32'(m_lvl[c]));
      check($sformatf("ch%0d tick", c),    32'(bus.tick[c]),    32'(m_tick[c]));
      check($sformatf("ch%0d busy", c),    32'(bus.busy[c]),    32'(m_pv[c]));
    end
  endtask

  task automatic do_load(input int ch, input int val);
    bus.load = 1'b1; bus.ch_sel = 3'(ch); bus.div_value = DIV_W'(val);
    step();
    bus.load = 1'b0;
  endtask

  bit hist [60];
  int run_start, run_len, min_run, last_run, n_runs;

  initial begin
    reset = 1'b1; bus.en = 1'b1; bus.load = 1'b0; bus.ch_sel = '0; bus.div_value = '0;
    step();
    check("reset clk_out", 32'(bus.clk_out), 0);
    check("reset tick",    32'(bus.tick),    0);
    check("reset busy",    32'(bus.busy),    0);
    reset = 1'b0;

    // Default D = 2: ch0 rises on edge 2; ch1 gets 5 loaded at edge 3.
    step(); check("edge1 clk0", 32'(bus.clk_out[0]), 0);
    step(); check("edge2 clk0", 32'(bus.clk_out[0]), 1); check("edge2 tick0", 32'(bus.tick[0]), 1);
    do_load(1, 5);
    check("edge3 busy1", 32'(bus.busy[1]), 1);
    for (int k = 4; k < 64; k++) begin
      step();
      check("dflt clk0",  32'(bus.clk_out[0]), 32'((k / 2) % 2));
      check("dflt tick0", 32'(bus.tick[0]),    32'(k % 2 == 0));
      hist[k-4] = bus.clk_out[1];
    end
    // Phase lengths of ch1 across the divisor switch.
    run_start = 0; min_run = 1000; last_run = 0; n_runs = 0;
    for (int i = 1; i < 60; i++) begin
      if (hist[i] != hist[i-1]) begin
        run_len = i - run_start;
        if (n_runs > 0 && run_len < min_run) min_run = run_len;
        last_run = run_len; n_runs++;
        run_start = i;
      end
    end
    check("ch1 no runt phase", 32'(min_run >= 2), 1);
    check("ch1 new half-period", 32'(last_run), 5);

    // Disable ch0, then re-enable with D = 3.
    do_load(0, 0);
    repeat (6) step();
    check("ch0 disabled", 32'(bus.clk_out[0]), 0);
    do_load(0, 3);
    repeat (20) step();

    // Freeze for 7 cycles mid-count.
    repeat (3) step();
    bus.en = 1'b0;
    repeat (7) step();
    check("frozen tick", 32'(bus.tick), 0);
    bus.en = 1'b1;
    repeat (12) step();

    // Last load wins; out-of-range channel ignored.
    do_load(1, 7);
    do_load(1, 9);
    do_load(5, 1);
    repeat (45) step();

    // Reset with a simultaneous load mid-period.
    step();
    reset = 1'b1; bus.load = 1'b1; bus.ch_sel = 3'd0; bus.div_value = DIV_W'(7);
    step();
    check("rst+load busy",    32'(bus.busy),    0);
    check("rst+load clk_out", 32'(bus.clk_out), 0);
    reset = 1'b0; bus.load = 1'b0;
    step();
    step(); check("post-rst edge2 clk0", 32'(bus.clk_out[0]), 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 299) == 0);
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.load      = ($urandom_range(0, 7) == 0);
      bus.ch_sel    = 3'($urandom_range(0, 3));
      bus.div_value = DIV_W'($urandom_range(0, 6));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_clk_div_prog

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Multi-channel programmable clock divider/enable generator driven from the 100 MHz board clock.
- Each channel produces a 50%-duty divided clock and a one-cycle tick strobe.
- Each channel's half-period divisor is reloadable at runtime through a shared load port.
- Serves VGA pixel timing (25 MHz default), debounce/scan rates and stepper/servo pacing across the design.

Parameters:
NUM_CH, 2, number of independent divider channels (1..8)
DIV_W, 16, width of the half-period divisor and the channel counters
DEFAULT_HALF, 2, per-channel divisor after reset (2 gives 25 MHz from 100 MHz)

Ports:
clk100_mhz  in  1  system clock, 100 MHz
reset  in  1  synchronous active-high reset
en  in  1  global run enable; low freezes all counters
load  in  1  single-cycle strobe: write div_value into ch_sel's pending register
ch_sel  in  3  target channel for load
div_value  in  DIV_W  new half-period in clk100_mhz cycles; 0 disables the channel
clk_out  out  NUM_CH  divided clocks, one bit per channel
tick  out  NUM_CH  one-cycle pulse when the matching clk_out toggles
busy  out  NUM_CH  high while a channel has a pending divisor not yet applied

Behaviour:
- Interface: one clock, clk100_mhz. Reset is synchronous and active-high (port reset), sampled only on the rising edge of clk100_mhz.
- Reset values:
  - clk_out = 0, tick = 0, busy = 0.
  - Counters = 0.
  - Active and pending divisors = DEFAULT_HALF.
  - Reset overrides en and load in the same cycle.
- Per channel, with active divisor D >= 1:
  - cnt counts 0..D-1 while en = 1.
  - On the edge where cnt == D-1: cnt <= 0, clk_out toggles, tick <= 1.
  - tick is high for exactly the cycle in which the new clk_out value is visible; it is 0 otherwise.
  - Output period is 2*D cycles at exactly 50% duty.
  - D = 1 gives 50 MHz, with tick high every cycle.
- en = 0:
  - cnt and clk_out hold.
  - tick is forced to 0.
  - Loads are still captured.
  - Counting resumes from the held cnt when en returns high.
- Load:
  - On an edge with load = 1 and ch_sel < NUM_CH: pending[ch_sel] <= div_value and busy[ch_sel] <= 1.
  - ch_sel >= NUM_CH is ignored.
  - Repeated loads before the divisor is applied: the last value wins.
- Glitch-free apply: pending is copied to active only on a wrap edge (cnt == D-1 with en = 1), in the same edge as the toggle. busy then clears.
- Applying 0 on a wrap edge:
  - Channel becomes disabled: clk_out <= 0, cnt <= 0, tick <= 0, regardless of the toggle.
- Disabled channel (active D = 0):
  - clk_out = 0, tick = 0.
  - A pending nonzero value is applied on the first edge after capture with en = 1; cnt <= 0.
  - First rising clk_out and tick occur D edges after the apply.
  - Loading 0 into a disabled channel simply clears busy on the next edge.
- Reset mid-operation: all channels return to reset values on that edge and pending loads are discarded.
- Widths: counter compare is unsigned DIV_W. No wrap-around beyond D-1 is possible; D = 2^DIV_W-1 is legal.

Decomposition:
- Shared package clk_div_pkg:
  - DIV_W default, DEFAULT_HALF, DIV_100_TO_25 = 2 constant.
  - div_t typedef (logic [DIV_W-1:0]).
- One sub-module, clk_div_chan:
  - Holds counter, active/pending registers, toggle, tick and busy for a single channel.
  - Instantiated NUM_CH times in a generate loop.
  - The top level only decodes load/ch_sel into per-channel load strobes.

Test Plan:
- Reset, en = 1, defaults: clk_out[0] rises at edge 2 and every 4 edges after; tick[0] high on edges 2, 4, 6...; busy = 0.
- Load ch1 = 5 at cycle 3 while its active D = 2: busy[1] = 1 until the next ch1 wrap; afterwards the period is 10 cycles, with no high or low phase shorter than 2 cycles across the switch.
- Load ch0 = 0: at ch0's next wrap clk_out[0] = 0, tick[0] stays 0. Then load 3: first rise 3 edges after the apply, period 6.
- en low for 7 cycles mid-count: clk_out and cnt frozen, tick = 0; the phase continues exactly where it stopped.
- Two loads to ch1 (7 then 9) before a wrap, plus a load with ch_sel = 5 (NUM_CH = 2): ch1 adopts 9; no channel changes from the ch_sel = 5 load.
- Assert reset with load = 1 in the same cycle mid-period: next edge all outputs 0, divisors = DEFAULT_HALF, the load is discarded, busy = 0.
